// File: rtl/str_unpack_gbox_if.sv
// rtl/str_unpack_gbox_if.sv - narrow-in / wide-out stream bundle for the unpacking gearbox
interface str_unpack_gbox_if #(
    parameter int DATA_UP_WIDTH = 8,
    parameter int DATA_DN_WIDTH = 24,
    parameter int CNT_WIDTH     = 2
);
    logic [DATA_UP_WIDTH-1:0] up_data;
    logic                     up_last;
    logic                     up_val;
    logic                     up_rdy;
    logic [DATA_DN_WIDTH-1:0] dn_data;
    logic                     dn_last;
    logic [CNT_WIDTH-1:0]     dn_cnt;
    logic                     dn_val;
    logic                     dn_rdy;

    modport slave (
        input  up_data, up_last, up_val,
        output up_rdy,
        output dn_data, dn_last, dn_cnt, dn_val,
        input  dn_rdy
    );

    modport master (
        output up_data, up_last, up_val,
        input  up_rdy,
        input  dn_data, dn_last, dn_cnt, dn_val,
        output dn_rdy
    );
endinterface

// File: rtl/str_unpack_gbox.sv
// rtl/str_unpack_gbox.sv - packs narrow upstream words into wide downstream words, first word in LSBs
module str_unpack_gbox #(
    parameter int DATA_UP_WIDTH = 8,
    parameter int DATA_DN_WIDTH = 24,
    parameter int CNT_WIDTH     = 2
) (
    input  logic               clk,
    input  logic               rst,
    str_unpack_gbox_if.slave   bus
);
    localparam int                   DATA_NB   = DATA_DN_WIDTH / DATA_UP_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(DATA_NB - 1);

    logic [DATA_DN_WIDTH-1:0] acc_data;
    logic [CNT_WIDTH-1:0]     acc_cnt;
    logic [DATA_DN_WIDTH-1:0] merged;
    logic [DATA_DN_WIDTH-1:0] dn_data_r;
    logic [CNT_WIDTH-1:0]     dn_cnt_r;
    logic                     dn_val_r;
    logic                     dn_last_r;
    logic                     out_free;
    logic                     up_rdy_c;
    logic                     up_fire;
    logic                     complete;

    // Lanes above acc_cnt are always zero, so OR-ing the new word in place builds the packed word.
    always_comb begin
        out_free = !dn_val_r || bus.dn_rdy;
        up_rdy_c = out_free || ((acc_cnt < LAST_LANE) && !bus.up_last);
        up_fire  = bus.up_val && up_rdy_c;
        complete = up_fire && ((acc_cnt == LAST_LANE) || bus.up_last);
        merged   = acc_data | (DATA_DN_WIDTH'(bus.up_data) << (DATA_UP_WIDTH * int'(acc_cnt)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_data  <= '0;
            acc_cnt   <= '0;
            dn_data_r <= '0;
            dn_cnt_r  <= '0;
            dn_last_r <= 1'b0;
            dn_val_r  <= 1'b0;
        end else if (complete) begin
            // A completion only happens when the output slot is free or draining this edge.
            dn_data_r <= merged;
            dn_cnt_r  <= acc_cnt + 1'b1;
            dn_last_r <= bus.up_last;
            dn_val_r  <= 1'b1;
            acc_data  <= '0;
            acc_cnt   <= '0;
        end else begin
            if (bus.dn_rdy) begin
                dn_val_r <= 1'b0;
            end
            if (up_fire) begin
                acc_data <= merged;
                acc_cnt  <= acc_cnt + 1'b1;
            end
        end
    end

    assign bus.up_rdy  = up_rdy_c;
    assign bus.dn_data = dn_data_r;
    assign bus.dn_cnt  = dn_cnt_r;
    assign bus.dn_last = dn_last_r;
    assign bus.dn_val  = dn_val_r;
endmodule

// File: tb/tb_str_unpack_gbox.sv
// tb/tb_str_unpack_gbox.sv - randomized and directed bench for str_unpack_gbox with a queue-based reference
module tb_str_unpack_gbox;
    localparam int UPW = 8;
    localparam int DNW = 24;
    localparam int CW  = 2;
    localparam int NB  = DNW / UPW;

    typedef struct {
        logic [DNW-1:0] d;
        int             cnt;
        bit             last;
    } wexp_t;

    logic clk;
    logic rst;

    str_unpack_gbox_if #(.DATA_UP_WIDTH(UPW), .DATA_DN_WIDTH(DNW), .CNT_WIDTH(CW)) bus ();

    str_unpack_gbox #(.DATA_UP_WIDTH(UPW), .DATA_DN_WIDTH(DNW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [UPW-1:0] cur[$];
    wexp_t          exp_q[$];
    int             dn_words = 0;
    bit             expect_rdy_high = 0;
    bit             load_pending = 0;
    bit             prev_hold = 0;
    logic [27:0]    prev_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    endtask

    function automatic wexp_t pack_words();
        wexp_t w;
        longint v = 0;
        for (int k = 0; k < cur.size(); k++)
            v += longint'(cur[k]) * (longint'(1) << (UPW * k));
        w.d    = DNW'(v);
        w.cnt  = cur.size();
        w.last = 0;
        return w;
    endfunction

    task automatic step(output bit accepted);
        bit    uf, df;
        wexp_t w;
        @(negedge clk);
        uf = bus.up_val && bus.up_rdy;
        df = bus.dn_val && bus.dn_rdy;
        if (load_pending) check("latency_dn_val", 32'(bus.dn_val), 32'd1);
        if (prev_hold)
            check("hold_stable", 32'({bus.dn_val, bus.dn_last, bus.dn_cnt, bus.dn_data}), 32'(prev_out));
        if (expect_rdy_high && bus.up_val) check("cont_up_rdy", 32'(bus.up_rdy), 32'd1);
        if (df) begin
            dn_words++;
            if (exp_q.size() == 0) begin
                check("unexpected_dn_word", 32'(bus.dn_data), 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("dn_data", 32'(bus.dn_data), 32'(w.d));
                check("dn_cnt", 32'(bus.dn_cnt), 32'(w.cnt));
                check("dn_last", 32'(bus.dn_last), 32'(w.last));
            end
        end
        load_pending = 0;
        if (uf) begin
            cur.push_back(bus.up_data);
            if (cur.size() == NB || bus.up_last) begin
                w = pack_words();
                w.last = bus.up_last;
                exp_q.push_back(w);
                cur.delete();
                load_pending = 1;
            end
        end
        prev_hold = bus.dn_val && !bus.dn_rdy;
        prev_out  = {bus.dn_val, bus.dn_last, bus.dn_cnt, bus.dn_data};
        accepted  = uf;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [UPW-1:0] d, input bit last, output int tries);
        bit a = 0;
        tries = 0;
        bus.up_data = d;
        bus.up_last = last;
        bus.up_val  = 1'b1;
        while (!a && tries < 50) begin
            step(a);
            tries++;
        end
        if (!a) check("send_timeout", 32'd0, 32'd1);
        bus.up_val  = 1'b0;
        bus.up_last = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.up_val = 1'b0;
        cur.delete();
        exp_q.delete();
        load_pending = 0;
        prev_hold = 0;
        #2;
        check("rst_dn_val", 32'(bus.dn_val), 32'd0);
        check("rst_dn_flags", 32'({bus.dn_last, bus.dn_cnt}), 32'd0);
        check("rst_dn_data", 32'(bus.dn_data), 32'd0);
        check("rst_up_rdy", 32'(bus.up_rdy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int t;
        int base;
        bit a;
        rst = 1'b1;
        bus.up_data = '0;
        bus.up_last = 1'b0;
        bus.up_val  = 1'b0;
        bus.dn_rdy  = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // continuous streaming with no backpressure
        expect_rdy_high = 1;
        base = dn_words;
        for (int i = 1; i <= 6; i++) send(UPW'(i), 1'b0, t);
        idle(2);
        expect_rdy_high = 0;
        check("cont_word_count", 32'(dn_words - base), 32'd2);

        // short last, then next packet restarts at lane 0, then single-word packet
        send(8'h07, 1'b0, t);
        send(8'h08, 1'b1, t);
        send(8'h09, 1'b0, t);
        send(8'h0A, 1'b0, t);
        send(8'h0B, 1'b0, t);
        send(8'h0C, 1'b1, t);
        idle(2);
        check("short_drained", 32'(exp_q.size()), 32'd0);

        // backpressure
        bus.dn_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(UPW'(8'h11 + i), 1'b0, t);
        check("bp_held_data", 32'(bus.dn_data), 32'h131211);
        check("bp_held_val", 32'(bus.dn_val), 32'd1);
        bus.up_data = 8'h16;
        bus.up_val  = 1'b1;
        step(a);
        check("bp_stall_accept", 32'(a), 32'd0);
        check("bp_up_rdy", 32'(bus.up_rdy), 32'd0);
        step(a);
        bus.dn_rdy = 1'b1;
        step(a);
        check("bp_release_accept", 32'(a), 32'd1);
        bus.dn_rdy = 1'b0;
        bus.up_val = 1'b0;
        check("bp_new_data", 32'(bus.dn_data), 32'h161514);
        check("bp_new_cnt", 32'(bus.dn_cnt), 32'd3);
        check("bp_new_val", 32'(bus.dn_val), 32'd1);
        idle(3);
        bus.dn_rdy = 1'b1;
        idle(2);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-packet discards the partial word
        send(8'h21, 1'b0, t);
        send(8'h22, 1'b0, t);
        apply_reset();
        idle(2);
        check("post_rst_no_word", 32'(bus.dn_val), 32'd0);
        base = dn_words;
        send(8'h31, 1'b0, t);
        check("first_after_rst", 32'(t), 32'd1);
        send(8'h32, 1'b0, t);
        send(8'h33, 1'b0, t);
        idle(2);
        check("rst_word_count", 32'(dn_words - base), 32'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.up_val  = ($urandom_range(0, 3) != 0);
            bus.up_data = UPW'($urandom);
            bus.up_last = ($urandom_range(0, 4) == 0);
            bus.dn_rdy  = ($urandom_range(0, 9) < 7);
            step(a);
        end
        bus.up_val = 1'b0;
        bus.dn_rdy = 1'b1;
        idle(4);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
